mul_booth_seq: RTL and testbench

MUL_BOOTH_SEQ -- requirements
Module: mul_booth_seq

---
 rtl/mul_pkg.sv | 40 ++++
 rtl/booth_r4_dec.sv | 28 ++
 rtl/mul_booth_seq.sv | 119 +++++++++++
 tb/tb_mul_booth_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// ============================================================================
// Module      : mul_pkg
// Description : State and radix-4 Booth operation encodings for mul_booth_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_pkg;

    localparam int c_st_w = 2;
    typedef logic [c_st_w-1:0] state_t;

    localparam state_t c_idle = 2'd0;
    localparam state_t c_busy = 2'd1;
    localparam state_t c_done = 2'd2;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_op_t;

    // Group is {y[2i+1], y[2i], y[2i-1]}
    function automatic booth_op_t booth_decode(input logic [2:0] grp);
        booth_op_t op;
        case (grp)
            3'b001, 3'b010: op = POS1;
            3'b011:         op = POS2;
            3'b100:         op = NEG2;
            3'b101, 3'b110: op = NEG1;
            default:        op = ZERO;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_r4_dec.sv
// ============================================================================
// Module      : booth_r4_dec
// Description : Combinational radix-4 Booth group decoder -> {zero, two, neg}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_r4_dec
    import mul_pkg::*;
(
    input  logic [2:0] grp,
    output logic       zero,
    output logic       two,
    output logic       neg
);

    booth_op_t w_op;

    always_comb begin
        w_op = booth_decode(grp);
        zero = (w_op == ZERO);
        two  = (w_op == POS2) || (w_op == NEG2);
        neg  = (w_op == NEG1) || (w_op == NEG2);
    end

endmodule

`default_nettype wire

// File: rtl/mul_booth_seq.sv
// ============================================================================
// Module      : mul_booth_seq
// Description : Sequential radix-4 Booth multiplier, signed/unsigned operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_booth_seq
    import mul_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   op1,
    input  logic [W-1:0]   op2,
    input  logic           sgn1,
    input  logic           sgn2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] res
);

    localparam int N  = W / 2 + 1;
    localparam int CW = $clog2(N + 1);
    localparam int XW = 2 * W + 2;
    localparam logic [CW-1:0] c_last = CW'(N);

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic [XW-1:0]  r_acc;
    logic [XW-1:0]  r_mcand;
    logic [W+2:0]   r_y;
    logic [2*W-1:0] r_res;

    logic           w_zero;
    logic           w_two;
    logic           w_neg;
    logic [XW-1:0]  w_pp;
    logic [XW-1:0]  w_addend;
    logic [XW-1:0]  w_sum;
    logic           w_m_sign;
    logic           w_y_sign;

    assign w_m_sign = sgn1 & op1[W-1];
    assign w_y_sign = sgn2 & op2[W-1];

    booth_r4_dec u_dec (
        .grp  (r_y[2:0]),
        .zero (w_zero),
        .two  (w_two),
        .neg  (w_neg)
    );

    // Single adder; negation is invert plus carry-in
    always_comb begin
        w_pp     = w_two ? (r_mcand << 1) : r_mcand;
        w_addend = w_zero ? '0 : (w_neg ? ~w_pp : w_pp);
        w_sum    = r_acc + w_addend + {{(XW-1){1'b0}}, (w_neg & ~w_zero)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:  if (in_valid)        w_next = c_busy;
            c_busy:  if (r_cnt == c_last) w_next = c_done;
            c_done:  if (out_ready)       w_next = c_idle;
            default:                      w_next = c_idle;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_idle);
        out_valid = (r_state == c_done);
    end

    // Counter runs 0..N: N add cycles, then one cycle to publish the result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_y     <= '0;
            r_res   <= '0;
        end else if (r_state == c_idle) begin
            if (in_valid) begin
                r_cnt   <= '0;
                r_acc   <= '0;
                r_mcand <= {{(W+2){w_m_sign}}, op1};
                r_y     <= {{2{w_y_sign}}, op2, 1'b0};
            end
        end else if (r_state == c_busy) begin
            if (r_cnt == c_last) begin
                r_res <= r_acc[2*W-1:0];
            end else begin
                r_acc   <= w_sum;
                r_mcand <= r_mcand << 2;
                r_y     <= r_y >> 2;
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    assign res = r_res;

endmodule

`default_nettype wire

// File: tb/tb_mul_booth_seq.sv
// ============================================================================
// Module      : tb_mul_booth_seq
// Description : Self-checking bench for mul_booth_seq at W=32 and W=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_booth_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b0, s1_32 = 1'b0, s2_32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [63:0] res32;

    logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0, s1_8 = 1'b0, s2_8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] res8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul_booth_seq #(.W(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .op1(a32), .op2(b32), .sgn1(s1_32), .sgn2(s2_32),
        .out_valid(ov32), .out_ready(or32), .res(res32)
    );

    mul_booth_seq #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .op1(a8), .op2(b8), .sgn1(s1_8), .sgn2(s2_8),
        .out_valid(ov8), .out_ready(or8), .res(res8)
    );

    typedef struct {
        bit          w8;
        logic [31:0] a;
        logic [31:0] b;
        logic        s1;
        logic        s2;
        logic [63:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer product, truncated to 2W bits
    function automatic logic [63:0] model(input bit w8, input logic [31:0] a, input logic [31:0] b,
                                          input logic s1, input logic s2);
        longint x, y, p;
        if (w8) begin
            x = s1 ? longint'($signed(a[7:0])) : longint'(a[7:0]);
            y = s2 ? longint'($signed(b[7:0])) : longint'(b[7:0]);
            p = x * y;
            return {48'b0, p[15:0]};
        end
        x = s1 ? longint'($signed(a)) : longint'(a);
        y = s2 ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return p;
    endfunction

    task automatic run_mul(input bit w8, input logic [31:0] a, input logic [31:0] b,
                           input logic s1, input logic s2,
                           output logic [63:0] r, output int lat);
        int k;
        @(negedge clk);
        if (w8) begin
            a8 = a[7:0]; b8 = b[7:0]; s1_8 = s1; s2_8 = s2; iv8 = 1'b1;
        end else begin
            a32 = a; b32 = b; s1_32 = s1; s2_32 = s2; iv32 = 1'b1;
        end
        k = 0;
        while (!(w8 ? ir8 : ir32) && k < 60) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        iv8  = 1'b0;
        iv32 = 1'b0;
        lat  = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!(w8 ? ov8 : ov32) && lat < 60);
        if (!(w8 ? ov8 : ov32)) lat = 999;
        r = w8 ? {48'b0, res8} : res32;
    endtask

    task automatic take(input bit w8);
        @(negedge clk);
        if (w8) or8 = 1'b1; else or32 = 1'b1;
        @(negedge clk);
        or8  = 1'b0;
        or32 = 1'b0;
    endtask

    initial begin
        vec_t        tbl[9];
        logic [63:0] r;
        logic [63:0] held;
        int          lat;
        int          k;

        tbl[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h0000000000000001};
        tbl[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE00000001};
        tbl[2] = '{1'b0, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000};
        tbl[3] = '{1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFE00000002};
        tbl[4] = '{1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 64'hC000000080000000};
        tbl[5] = '{1'b1, 32'h7F, 32'h81, 1'b1, 1'b1, 64'h000000000000C0FF};
        tbl[6] = '{1'b1, 32'h80, 32'h80, 1'b1, 1'b1, 64'h0000000000004000};
        tbl[7] = '{1'b1, 32'hFF, 32'hFF, 1'b0, 1'b0, 64'h000000000000FE01};
        tbl[8] = '{1'b1, 32'h80, 32'hFF, 1'b0, 1'b1, 64'h000000000000FF80};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready32", {63'b0, ir32}, 64'd1);
        check("reset_out_valid32", {63'b0, ov32}, 64'd0);
        check("reset_res32", res32, 64'd0);
        check("reset_in_ready8", {63'b0, ir8}, 64'd1);
        check("reset_res8", {48'b0, res8}, 64'd0);

        for (int i = 0; i < 9; i++) begin
            run_mul(tbl[i].w8, tbl[i].a, tbl[i].b, tbl[i].s1, tbl[i].s2, r, lat);
            check($sformatf("table_res[%0d]", i), r, tbl[i].exp);
            check($sformatf("table_latency[%0d]", i), 64'(lat), tbl[i].w8 ? 64'd6 : 64'd18);
            take(tbl[i].w8);
        end

        for (int i = 0; i < 24; i++) begin
            bit          w8;
            logic [31:0] a, b;
            logic        s1, s2;
            w8 = (i % 2) == 1;
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) a = w8 ? 32'h80 : 32'h80000000;
            if ($urandom_range(0, 3) == 0) b = 32'hFFFFFFFF;
            s1 = 1'($urandom_range(0, 1));
            s2 = 1'($urandom_range(0, 1));
            run_mul(w8, a, b, s1, s2, r, lat);
            check($sformatf("random_res[%0d]", i), r, model(w8, a, b, s1, s2));
            take(w8);
        end

        // Result held in DONE while a new request waits
        run_mul(1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, held, lat);
        check("hold_initial_res", held, model(1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1));
        @(negedge clk);
        a32 = 32'd3; b32 = 32'd7; s1_32 = 1'b0; s2_32 = 1'b0; iv32 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_res[%0d]", c), res32, held);
            check($sformatf("hold_out_valid[%0d]", c), {63'b0, ov32}, 64'd1);
            check($sformatf("hold_in_ready[%0d]", c), {63'b0, ir32}, 64'd0);
        end
        @(negedge clk);
        or32 = 1'b1;
        @(posedge clk);
        #1;
        check("handshake_in_ready", {63'b0, ir32}, 64'd1);
        check("handshake_out_valid", {63'b0, ov32}, 64'd0);
        @(negedge clk);
        or32 = 1'b0;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        check("accept_after_idle", {63'b0, ir32}, 64'd0);
        k = 0;
        while (!ov32 && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("queued_res", res32, 64'd21);
        check("queued_latency", 64'(k), 64'd18);
        take(1'b0);

        // Reset in the middle of BUSY
        @(negedge clk);
        a32 = 32'hDEADBEEF; b32 = 32'h01234567; s1_32 = 1'b1; s2_32 = 1'b1; iv32 = 1'b1;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", {63'b0, ir32}, 64'd1);
        check("abort_out_valid", {63'b0, ov32}, 64'd0);
        check("abort_res", res32, 64'd0);
        run_mul(1'b0, 32'd3, 32'd5, 1'b0, 1'b0, r, lat);
        check("after_abort_res", r, 64'd15);
        check("after_abort_latency", 64'(lat), 64'd18);
        take(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
